// File: rtl/ofifo_drain_pkg.sv
// Shared types and lane geometry for the ofifo drain engine.
package ofifo_drain_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    WB   = 2'd2,
    FIN  = 2'd3
  } drain_state_t;

  localparam int COL_DEFAULT     = 8;
  localparam int PSUM_BW_DEFAULT = 16;
  localparam int ADDR_W_DEFAULT  = 11;
  localparam int ROW_W_DEFAULT   = COL_DEFAULT * PSUM_BW_DEFAULT;

  // Low bit of a lane inside a packed row.
  function automatic int lane_lsb(input int lane, input int bw);
    return lane * bw;
  endfunction

  // Total packed width of one psum row.
  function automatic int row_width(input int lanes, input int bw);
    return lanes * bw;
  endfunction

endpackage

// File: rtl/ofifo_drain_if.sv
// Bus bundle between the drain engine, the ofifo read port and the psum SRAM.
interface ofifo_drain_if
  import ofifo_drain_pkg::*;
#(
  parameter int col     = COL_DEFAULT,
  parameter int psum_bw = PSUM_BW_DEFAULT,
  parameter int addr_w  = ADDR_W_DEFAULT
);
  localparam int ROW_W = row_width(col, psum_bw);

  logic              ofifo_valid;
  logic [ROW_W-1:0]  ofifo_out;
  logic              ofifo_rd;
  logic              sram_cen;
  logic              sram_wen;
  logic [addr_w-1:0] sram_addr;
  logic [ROW_W-1:0]  sram_d;
  logic [ROW_W-1:0]  sram_q;

  // Drain engine side.
  modport master (
    input  ofifo_valid, ofifo_out, sram_q,
    output ofifo_rd, sram_cen, sram_wen, sram_addr, sram_d
  );

  // ofifo / SRAM side.
  modport slave (
    output ofifo_valid, ofifo_out, sram_q,
    input  ofifo_rd, sram_cen, sram_wen, sram_addr, sram_d
  );

endinterface

// File: rtl/ofifo_drain_lane_alu.sv
// One psum lane: wrap-around accumulate (bypassed in overwrite mode) then ReLU.
module psum_lane_alu
  import ofifo_drain_pkg::*;
#(
  parameter int psum_bw = PSUM_BW_DEFAULT
) (
  input  logic [psum_bw-1:0] operand,
  input  logic [psum_bw-1:0] stored,
  input  logic               acc_en,
  input  logic               relu_en,
  output logic [psum_bw-1:0] result
);

  logic [psum_bw-1:0] sum;

  // Two's-complement add wraps naturally at psum_bw; ReLU zeroes negative sums.
  always_comb begin
    sum    = acc_en ? (operand + stored) : operand;
    result = (relu_en && sum[psum_bw-1]) ? '0 : sum;
  end

endmodule

// File: rtl/ofifo_drain.sv
// Drains complete psum rows from the ofifo into the psum SRAM, either
// overwriting or accumulating (read-modify-write) with optional ReLU.
module ofifo_drain
  import ofifo_drain_pkg::*;
#(
  parameter int col     = COL_DEFAULT,
  parameter int psum_bw = PSUM_BW_DEFAULT,
  parameter int addr_w  = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [addr_w-1:0] base_addr,
  input  logic [addr_w-1:0] num_rows,
  input  logic              acc_en,
  input  logic              relu_en,
  ofifo_drain_if.master     bus,
  output logic              busy,
  output logic              done
);

  localparam int                ROW_W    = row_width(col, psum_bw);
  localparam logic [addr_w-1:0] ADDR_ONE = addr_w'(1);

  drain_state_t      state;
  logic [addr_w-1:0] addr;
  logic [addr_w-1:0] cnt;
  logic [addr_w-1:0] num_rows_r;
  logic              acc_r;
  logic              relu_r;
  logic [ROW_W-1:0]  row_r;

  logic              pop_fire;
  logic              wb_fire;
  logic              wr_fire;
  logic              last_row;
  logic [ROW_W-1:0]  alu_a;
  logic [ROW_W-1:0]  alu_out;

  for (genvar i = 0; i < col; i++) begin : g_lane
    psum_lane_alu #(
      .psum_bw (psum_bw)
    ) u_alu (
      .operand (alu_a[lane_lsb(i, psum_bw) +: psum_bw]),
      .stored  (bus.sram_q[lane_lsb(i, psum_bw) +: psum_bw]),
      .acc_en  (acc_r),
      .relu_en (relu_r),
      .result  (alu_out[lane_lsb(i, psum_bw) +: psum_bw])
    );
  end

  // Strobe and SRAM bus decode; reset masks the strobes so an in-flight
  // pop or write is dropped in the reset cycle itself.
  always_comb begin
    pop_fire      = (state == POP) && bus.ofifo_valid && !reset;
    wb_fire       = (state == WB) && !reset;
    wr_fire       = wb_fire || (pop_fire && !acc_r);
    last_row      = (cnt == (num_rows_r - ADDR_ONE));
    alu_a         = (state == WB) ? row_r : bus.ofifo_out;
    bus.ofifo_rd  = pop_fire;
    bus.sram_cen  = !(pop_fire || wb_fire);
    bus.sram_wen  = !wr_fire;
    bus.sram_addr = addr;
    bus.sram_d    = wr_fire ? alu_out : '0;
  end

  // Transfer FSM with address/row counters and registered busy/done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr       <= '0;
      cnt        <= '0;
      num_rows_r <= '0;
      acc_r      <= 1'b0;
      relu_r     <= 1'b0;
      row_r      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= (state == FIN);
      if (wr_fire) begin
        addr <= addr + ADDR_ONE;
        cnt  <= cnt + ADDR_ONE;
      end
      if (pop_fire) begin
        row_r <= bus.ofifo_out;
      end
      case (state)
        IDLE: begin
          if (start) begin
            addr       <= base_addr;
            cnt        <= '0;
            num_rows_r <= num_rows;
            acc_r      <= acc_en;
            relu_r     <= relu_en;
            busy       <= 1'b1;
            state      <= (num_rows == '0) ? FIN : POP;
          end
        end
        POP: begin
          if (bus.ofifo_valid) begin
            if (acc_r) begin
              state <= WB;
            end else if (last_row) begin
              state <= FIN;
            end
          end
        end
        WB: begin
          state <= last_row ? FIN : POP;
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ofifo_drain.sv
// Self-checking bench for ofifo_drain: ofifo and SRAM models plus a write scoreboard.
module tb_ofifo_drain;

  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int AW    = 11;
  localparam int ROW_W = COL * BW;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [ROW_W-1:0] data;
  } wr_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] num_rows;
  logic          acc_en;
  logic          relu_en;
  logic          busy;
  logic          done;

  ofifo_drain_if #(.col(COL), .psum_bw(BW), .addr_w(AW)) bus ();

  ofifo_drain #(.col(COL), .psum_bw(BW), .addr_w(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .acc_en    (acc_en),
    .relu_en   (relu_en),
    .bus       (bus),
    .busy      (busy),
    .done      (done)
  );

  int n_cmp = 0;
  int n_err = 0;
  wr_t exp_q[$];

  // ofifo model
  logic [ROW_W-1:0] fifo_mem [0:63];
  int               wr_ptr = 0;
  int               rd_ptr = 0;
  logic             valid_en;

  // SRAM model
  logic [ROW_W-1:0] mem [0:(1<<AW)-1];
  logic             pl_en;
  logic [AW-1:0]    pl_addr;
  logic [ROW_W-1:0] pl_data;

  assign bus.ofifo_valid = valid_en && (wr_ptr != rd_ptr);
  assign bus.ofifo_out   = fifo_mem[rd_ptr[5:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) rd_ptr <= wr_ptr;
    else if (bus.ofifo_rd) rd_ptr <= rd_ptr + 1;
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (!bus.sram_cen) begin
      if (!bus.sram_wen) mem[bus.sram_addr] <= bus.sram_d;
      else bus.sram_q <= mem[bus.sram_addr];
    end
  end

  function automatic logic [ROW_W-1:0] splat(input logic [BW-1:0] v);
    logic [ROW_W-1:0] r;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = v;
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] seq_row(input logic [BW-1:0] first);
    logic [ROW_W-1:0] r;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = first + BW'(i);
    return r;
  endfunction

  task automatic push_row(input logic [ROW_W-1:0] r);
    fifo_mem[wr_ptr[5:0]] = r;
    wr_ptr++;
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [ROW_W-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [ROW_W-1:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic launch(input logic [AW-1:0] b, input logic [AW-1:0] n, input logic acc, input logic relu);
    @(negedge clk);
    base_addr = b; num_rows = n; acc_en = acc; relu_en = relu; start = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.ofifo_rd, bus.sram_cen, bus.sram_wen, bus.sram_addr, bus.sram_d, busy, done}
        !== {1'b0, 1'b1, 1'b1, {AW{1'b0}}, {ROW_W{1'b0}}, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got rd=%b cen=%b wen=%b addr=%h d=%h busy=%b done=%b, required 0 1 1 0 0 0 0",
               bus.ofifo_rd, bus.sram_cen, bus.sram_wen, bus.sram_addr, bus.sram_d, busy, done);
    end
    reset = 1'b0;
  endtask

  task automatic test_overwrite;
    wr_t e;
    valid_en = 1'b1;
    for (int r = 0; r < 4; r++) begin
      push_row(seq_row(BW'((r << 8) + 1)));
      expect_wr(AW'(16 + r), seq_row(BW'((r << 8) + 1)));
    end
    launch(11'h010, 11'd4, 1'b0, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (!bus.sram_cen && !bus.sram_wen) begin
        n_cmp++;
        if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
        if (bus.sram_addr !== e.addr || bus.sram_d !== e.data) begin
          n_err++;
          $display("FAIL ovw_write: got @%h %h, required @%h %h", bus.sram_addr, bus.sram_d, e.addr, e.data);
        end
      end
      n_cmp++;
      if (bus.ofifo_rd !== (c <= 4)) begin
        n_err++;
        $display("FAIL ovw_rd: cycle %0d got %b, required %b", c, bus.ofifo_rd, (c <= 4));
      end
      n_cmp++;
      if (done !== (c == 6)) begin
        n_err++;
        $display("FAIL ovw_done: cycle %0d got %b, required %b", c, done, (c == 6));
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL ovw_missing: got %0d writes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_accumulate;
    wr_t e;
    logic wr_strobe;
    for (int r = 0; r < 3; r++) begin
      preload(AW'(32 + r), splat(16'd100));
      push_row(splat(16'hFFE2));
      expect_wr(AW'(32 + r), splat(16'd70));
    end
    launch(11'h020, 11'd3, 1'b1, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      wr_strobe = !bus.sram_cen && !bus.sram_wen;
      if (wr_strobe) begin
        n_cmp++;
        if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
        if (bus.sram_addr !== e.addr || bus.sram_d !== e.data) begin
          n_err++;
          $display("FAIL acc_write: got @%h %h, required @%h %h", bus.sram_addr, bus.sram_d, e.addr, e.data);
        end
      end
      n_cmp++;
      if (bus.ofifo_rd !== (c % 2 == 1 && c <= 5) || wr_strobe !== (c % 2 == 0 && c <= 6)) begin
        n_err++;
        $display("FAIL acc_spacing: cycle %0d got rd=%b wr=%b, required rd=%b wr=%b", c,
                 bus.ofifo_rd, wr_strobe, (c % 2 == 1 && c <= 5), (c % 2 == 0 && c <= 6));
      end
      n_cmp++;
      if (done !== (c == 8)) begin
        n_err++;
        $display("FAIL acc_done: cycle %0d got %b, required %b", c, done, (c == 8));
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL acc_missing: got %0d writes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_relu;
    wr_t e;
    preload(11'h030, splat(16'd10));
    preload(11'h031, splat(16'd40));
    push_row(splat(16'hFFE7));
    push_row(splat(16'hFFE7));
    expect_wr(11'h030, splat(16'd0));
    expect_wr(11'h031, splat(16'd15));
    launch(11'h030, 11'd2, 1'b1, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (!bus.sram_cen && !bus.sram_wen) begin
        n_cmp++;
        if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
        if (bus.sram_addr !== e.addr || bus.sram_d !== e.data) begin
          n_err++;
          $display("FAIL relu_write: got @%h %h, required @%h %h", bus.sram_addr, bus.sram_d, e.addr, e.data);
        end
      end
      n_cmp++;
      if (done !== (c == 6)) begin
        n_err++;
        $display("FAIL relu_done: cycle %0d got %b, required %b", c, done, (c == 6));
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL relu_missing: got %0d writes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // k=0: 0x7FFF+1 wraps; k=1: same with ReLU; k=2: address wraps past 0x7FF.
  task automatic test_wrap;
    wr_t e;
    preload(11'h040, splat(16'h7FFF));
    preload(11'h041, splat(16'h7FFF));
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin
        push_row(splat(16'h0001)); expect_wr(11'h040, splat(16'h8000));
        launch(11'h040, 11'd1, 1'b1, 1'b0);
      end else if (k == 1) begin
        push_row(splat(16'h0001)); expect_wr(11'h041, splat(16'h0000));
        launch(11'h041, 11'd1, 1'b1, 1'b1);
      end else begin
        push_row(seq_row(16'h0A01)); expect_wr(11'h7FF, seq_row(16'h0A01));
        push_row(seq_row(16'h0B01)); expect_wr(11'h000, seq_row(16'h0B01));
        launch(11'h7FF, 11'd2, 1'b0, 1'b0);
      end
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        if (c == 1) start = 1'b0;
        if (!bus.sram_cen && !bus.sram_wen) begin
          n_cmp++;
          if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
          if (bus.sram_addr !== e.addr || bus.sram_d !== e.data) begin
            n_err++;
            $display("FAIL wrap_write k=%0d: got @%h %h, required @%h %h", k, bus.sram_addr, bus.sram_d, e.addr, e.data);
          end
        end
        n_cmp++;
        if (done !== (c == 4)) begin
          n_err++;
          $display("FAIL wrap_done k=%0d: cycle %0d got %b, required %b", k, c, done, (c == 4));
        end
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_err++;
        $display("FAIL wrap_missing k=%0d: got %0d writes outstanding, required 0", k, exp_q.size());
        exp_q.delete();
      end
    end
  endtask

  task automatic test_valid_toggle;
    wr_t e;
    int pops;
    pops = 0;
    for (int r = 0; r < 3; r++) begin
      push_row(seq_row(BW'((r << 8) + 16'h0C01)));
      expect_wr(AW'(16'h050 + r), seq_row(BW'((r << 8) + 16'h0C01)));
    end
    launch(11'h050, 11'd3, 1'b0, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk);
      #1 valid_en = !(c == 2 || c == 3);
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (bus.ofifo_rd) begin
        pops++;
        n_cmp++;
        if (!bus.ofifo_valid) begin
          n_err++;
          $display("FAIL tog_rd_no_valid: cycle %0d got rd=1 with valid=0, required rd=0", c);
        end
      end
      n_cmp++;
      if (bus.ofifo_rd !== (c == 1 || c == 4 || c == 5)) begin
        n_err++;
        $display("FAIL tog_rd: cycle %0d got %b, required %b", c, bus.ofifo_rd, (c == 1 || c == 4 || c == 5));
      end
      if (!bus.sram_cen && !bus.sram_wen) begin
        n_cmp++;
        if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
        if (bus.sram_addr !== e.addr || bus.sram_d !== e.data) begin
          n_err++;
          $display("FAIL tog_write: got @%h %h, required @%h %h", bus.sram_addr, bus.sram_d, e.addr, e.data);
        end
      end
      n_cmp++;
      if (done !== (c == 7)) begin
        n_err++;
        $display("FAIL tog_done: cycle %0d got %b, required %b", c, done, (c == 7));
      end
    end
    n_cmp++;
    if (pops != 3 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL tog_count: got %0d pops and %0d writes outstanding, required 3 and 0", pops, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid;
    wr_t e;
    preload(11'h060, splat(16'd5));
    preload(11'h061, splat(16'd5));
    push_row(splat(16'd1));
    push_row(splat(16'd1));
    expect_wr(11'h060, splat(16'd6));
    launch(11'h060, 11'd2, 1'b1, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c <= 2 && !bus.sram_cen && !bus.sram_wen) begin
        n_cmp++;
        if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
        if (bus.sram_addr !== e.addr || bus.sram_d !== e.data) begin
          n_err++;
          $display("FAIL rst_write: got @%h %h, required @%h %h", bus.sram_addr, bus.sram_d, e.addr, e.data);
        end
      end
      if (c == 2) reset = 1'b1;
      if (c >= 3) begin
        n_cmp++;
        if ({bus.ofifo_rd, bus.sram_cen, busy, done} !== 4'b0100) begin
          n_err++;
          $display("FAIL rst_idle: cycle %0d got rd=%b cen=%b busy=%b done=%b, required 0 1 0 0",
                   c, bus.ofifo_rd, bus.sram_cen, busy, done);
        end
      end
      if (c == 3) reset = 1'b0;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rst_missing: got %0d writes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_zero_rows;
    launch(11'h070, 11'd0, 1'b0, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      n_cmp++;
      if (bus.sram_cen !== 1'b1 || bus.ofifo_rd !== 1'b0) begin
        n_err++;
        $display("FAIL zero_access: cycle %0d got cen=%b rd=%b, required cen=1 rd=0", c, bus.sram_cen, bus.ofifo_rd);
      end
      n_cmp++;
      if (done !== (c == 2)) begin
        n_err++;
        $display("FAIL zero_done: cycle %0d got %b, required %b", c, done, (c == 2));
      end
    end
  endtask

  task automatic test_busy_start;
    wr_t e;
    int writes;
    writes = 0;
    for (int r = 0; r < 3; r++) begin
      push_row(seq_row(BW'(16'hF000 + (r << 4))));
      expect_wr(AW'(16'h100 + r), seq_row(BW'(16'hF000 + (r << 4))));
    end
    launch(11'h100, 11'd3, 1'b0, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (!bus.sram_cen && !bus.sram_wen) begin
        writes++;
        n_cmp++;
        if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
        if (bus.sram_addr !== e.addr || bus.sram_d !== e.data) begin
          n_err++;
          $display("FAIL busy_write: got @%h %h, required @%h %h", bus.sram_addr, bus.sram_d, e.addr, e.data);
        end
      end
      n_cmp++;
      if (done !== (c == 5)) begin
        n_err++;
        $display("FAIL busy_done: cycle %0d got %b, required %b", c, done, (c == 5));
      end
      if (c == 1) start = 1'b0;
      if (c == 2) begin
        base_addr = 11'h200; num_rows = 11'd1; acc_en = 1'b1; relu_en = 1'b1; start = 1'b1;
      end
      if (c == 3) start = 1'b0;
    end
    n_cmp++;
    if (writes != 3 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL busy_count: got %0d writes and %0d outstanding, required 3 and 0", writes, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0;
    acc_en = 1'b0; relu_en = 1'b0; valid_en = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.sram_q = '0;
    test_reset;
    test_overwrite;
    test_accumulate;
    test_relu;
    test_wrap;
    test_valid_toggle;
    test_reset_mid;
    test_zero_rows;
    test_busy_start;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
